// File: rtl/vec_wb_diff_queue.sv
// vec_wb_diff_queue
//   Producer side of the vector-writeback difftest event channel. Each cycle it
//   samples up to NPORTS vector register writebacks, compacts the valid ones in
//   ascending port order into a circular queue and drains the queue at one event
//   per cycle into the difftest sink. Writebacks that find no room are dropped
//   and accounted for in a sticky overflow flag and a saturating drop counter.
//
// Parameters
//   NPORTS  writeback ports sampled per cycle (1..4)
//   DEPTH   queue entries, power of two, at least 2*NPORTS
//   ADDR_W  vector register address width
//
// Ports
//   clock         single clock, all state updates on its rising edge
//   reset         synchronous, active-low (0 = reset)
//   wb_valid      per-port writeback valid
//   wb_addr       port i address at [ADDR_W*i +: ADDR_W]
//   wb_data       port i data at [128*i +: 128]; low 64 -> data_0, high 64 -> data_1
//   coreid        hart id, captured when an entry is popped
//   diff_ready    sink can take an event this cycle
//   wb_ready      registered: at least NPORTS free entries (advisory only)
//   diff_enable   one-cycle strobe per emitted event
//   diff_valid    same as diff_enable
//   diff_address  event register address (holds last value between events)
//   diff_data_0   event data low half
//   diff_data_1   event data high half
//   diff_coreid   event hart id
//   overflow      sticky, at least one writeback was dropped
//   drop_cnt      dropped writeback count, saturates at 16'hFFFF

module vec_wb_diff_queue #(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        wb_valid,
  input  logic [NPORTS*ADDR_W-1:0] wb_addr,
  input  logic [NPORTS*128-1:0]    wb_data,
  input  logic [7:0]               coreid,
  input  logic                     diff_ready,
  output logic                     wb_ready,
  output logic                     diff_enable,
  output logic                     diff_valid,
  output logic [ADDR_W-1:0]        diff_address,
  output logic [63:0]              diff_data_0,
  output logic [63:0]              diff_data_1,
  output logic [7:0]               diff_coreid,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NPORTS_C = CNT_W'(NPORTS);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  // Queue storage; contents are don't-care until written, so no reset.
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [127:0]      mem_data [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             pop;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] pushed;
  logic [CNT_W-1:0] dropped;
  logic [CNT_W-1:0] count_next;
  logic             wb_ready_next;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  logic [NPORTS-1:0] port_we;
  logic [PTR_W-1:0]  port_idx [NPORTS];

  assign diff_valid = diff_enable;

  // Pop decision, free space and port compaction. The slot freed by a pop in
  // this cycle is counted as free, so a full queue that is draining still
  // accepts one writeback. Ports are walked in ascending order, so when space
  // runs out it is always the highest-numbered valid ports that are dropped.
  always_comb begin
    pop        = (count != '0) && diff_ready;
    free_slots = DEPTH_C - count + (pop ? ONE_C : '0);
    pushed     = '0;
    dropped    = '0;
    port_we    = '0;
    for (int i = 0; i < NPORTS; i++) begin
      port_idx[i] = '0;
      if (wb_valid[i]) begin
        if (pushed < free_slots) begin
          port_we[i]  = 1'b1;
          port_idx[i] = tail + pushed[PTR_W-1:0];
          pushed      = pushed + ONE_C;
        end else begin
          dropped = dropped + ONE_C;
        end
      end
    end
    count_next    = count + pushed - (pop ? ONE_C : '0);
    wb_ready_next = (DEPTH_C - count_next) >= NPORTS_C;
    drop_sum      = {1'b0, drop_cnt} + 17'(dropped);
    drop_next     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Entry writes; each accepted port lands in its own compacted slot.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (reset && port_we[i]) begin
        mem_addr[port_idx[i]] <= wb_addr[ADDR_W*i +: ADDR_W];
        mem_data[port_idx[i]] <= wb_data[128*i +: 128];
      end
    end
  end

  // Pointers, occupancy, drop accounting and the registered event outputs.
  // The popped entry is read from the old head in the same edge it is
  // removed, so an event always comes out one cycle after the pop decision
  // and never straight from the writeback inputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      wb_ready     <= 1'b1;
      diff_enable  <= 1'b0;
      diff_address <= '0;
      diff_data_0  <= '0;
      diff_data_1  <= '0;
      diff_coreid  <= '0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      tail        <= tail + pushed[PTR_W-1:0];
      count       <= count_next;
      wb_ready    <= wb_ready_next;
      diff_enable <= pop;
      drop_cnt    <= drop_next;
      if (dropped != '0) begin
        overflow <= 1'b1;
      end
      if (pop) begin
        head         <= head + 1'b1;
        diff_address <= mem_addr[head];
        diff_data_0  <= mem_data[head][63:0];
        diff_data_1  <= mem_data[head][127:64];
        diff_coreid  <= coreid;
      end
    end
  end

endmodule

// File: tb/tb_vec_wb_diff_queue.sv
// tb_vec_wb_diff_queue
//   Bench for vec_wb_diff_queue (NPORTS=2, DEPTH=8). A queue-based reference
//   model predicts every output each cycle; a hand-built table adds explicit
//   expectations for reset, ordering, overflow, full-with-pop and mid-run reset.

module tb_vec_wb_diff_queue;

  localparam int NP = 2;
  localparam int DP = 8;

  logic          clock;
  logic          reset;
  logic [NP-1:0] wb_valid;
  logic [15:0]   wb_addr;
  logic [255:0]  wb_data;
  logic [7:0]    coreid;
  logic          diff_ready;
  logic          wb_ready;
  logic          diff_enable;
  logic          diff_valid;
  logic [7:0]    diff_address;
  logic [63:0]   diff_data_0;
  logic [63:0]   diff_data_1;
  logic [7:0]    diff_coreid;
  logic          overflow;
  logic [15:0]   drop_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_wb_diff_queue #(.NPORTS(NP), .DEPTH(DP), .ADDR_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .coreid       (coreid),
    .diff_ready   (diff_ready),
    .wb_ready     (wb_ready),
    .diff_enable  (diff_enable),
    .diff_valid   (diff_valid),
    .diff_address (diff_address),
    .diff_data_0  (diff_data_0),
    .diff_data_1  (diff_data_1),
    .diff_coreid  (diff_coreid),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a plain queue of pending writebacks plus the values the
  // sink side should currently show.
  typedef struct {
    logic [7:0]   addr;
    logic [127:0] data;
  } ent_t;

  ent_t        mq[$];
  logic        exp_en;
  logic [7:0]  exp_addr;
  logic [63:0] exp_d0;
  logic [63:0] exp_d1;
  logic [7:0]  exp_cid;
  logic        exp_ovf;
  int          exp_drop;
  logic        exp_rdy;

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic        ready;
    logic        en;
    logic [7:0]  addr;
    logic        ovf;
    logic [15:0] drop;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [127:0] mkdata(input logic [7:0] a);
    return {56'h5A5A5A5A5A5A5A, a, 56'hC3C3C3C3C3C3C3, ~a};
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    int   ndrop;
    ent_t e;
    if (!reset) begin
      mq.delete();
      exp_en   = 1'b0;
      exp_addr = '0;
      exp_d0   = '0;
      exp_d1   = '0;
      exp_cid  = '0;
      exp_ovf  = 1'b0;
      exp_drop = 0;
      exp_rdy  = 1'b1;
    end else begin
      exp_en = 1'b0;
      if (mq.size() > 0 && diff_ready) begin
        e        = mq.pop_front();
        exp_en   = 1'b1;
        exp_addr = e.addr;
        exp_d0   = e.data[63:0];
        exp_d1   = e.data[127:64];
        exp_cid  = coreid;
      end
      ndrop = 0;
      for (int i = 0; i < NP; i++) begin
        if (wb_valid[i]) begin
          if (mq.size() < DP) begin
            e.addr = wb_addr[8*i +: 8];
            e.data = wb_data[128*i +: 128];
            mq.push_back(e);
          end else begin
            ndrop++;
          end
        end
      end
      if (ndrop > 0) exp_ovf = 1'b1;
      exp_drop = exp_drop + ndrop;
      if (exp_drop > 65535) exp_drop = 65535;
      exp_rdy = (DP - mq.size()) >= NP;
    end
  endtask

  task automatic checkOutput();
    cmp("diff_enable", diff_enable, exp_en);
    cmp("diff_valid", diff_valid, exp_en);
    cmp("diff_address", diff_address, exp_addr);
    cmp("diff_data_0", diff_data_0, exp_d0);
    cmp("diff_data_1", diff_data_1, exp_d1);
    cmp("diff_coreid", diff_coreid, exp_cid);
    cmp("overflow", overflow, exp_ovf);
    cmp("drop_cnt", drop_cnt, 16'(exp_drop));
    cmp("wb_ready", wb_ready, exp_rdy);
  endtask

  // Drives one cycle of inputs, clocks it, steps the model and checks #1
  // after the edge.
  task automatic applyStimulus(input logic rst, input logic [1:0] v, input logic [15:0] a,
                               input logic [255:0] d, input logic rdy, input logic [7:0] cid);
    reset      = rst;
    wb_valid   = v;
    wb_addr    = a;
    wb_data    = d;
    diff_ready = rdy;
    coreid     = cid;
    @(posedge clock);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic addRow(input logic rst, input logic [1:0] valid, input logic [7:0] a0,
                        input logic [7:0] a1, input logic ready, input logic en,
                        input logic [7:0] addr, input logic ovf, input logic [15:0] drop,
                        input logic rdy);
    vec_t r;
    r.rst = rst; r.valid = valid; r.a0 = a0; r.a1 = a1; r.ready = ready;
    r.en = en; r.addr = addr; r.ovf = ovf; r.drop = drop; r.rdy = rdy;
    tbl.push_back(r);
  endtask

  initial begin
    logic [255:0] rd;
    logic [15:0]  ra;
    logic         rready;

    reset      = 1'b0;
    wb_valid   = '0;
    wb_addr    = '0;
    wb_data    = '0;
    coreid     = '0;
    diff_ready = 1'b0;
    exp_drop   = 0;

    // Reset held with both ports valid: nothing may get in.
    for (int k = 0; k < 3; k++) addRow(0, 2'b11, 8'h10, 8'h11, 1, 0, 8'h00, 0, 16'd0, 1);
    // Ordering: two ports for three cycles, six consecutive events.
    addRow(1, 2'b11, 8'h00, 8'h01, 1, 0, 8'h00, 0, 16'd0, 1);
    addRow(1, 2'b11, 8'h02, 8'h03, 1, 1, 8'h00, 0, 16'd0, 1);
    addRow(1, 2'b11, 8'h04, 8'h05, 1, 1, 8'h01, 0, 16'd0, 1);
    for (int k = 2; k < 6; k++) addRow(1, 2'b00, 8'h00, 8'h00, 1, 1, 8'(k), 0, 16'd0, 1);
    addRow(1, 2'b00, 8'h00, 8'h00, 1, 0, 8'h05, 0, 16'd0, 1);
    // Overflow: ten writes into eight entries with the sink stalled.
    addRow(1, 2'b11, 8'h00, 8'h01, 0, 0, 8'h05, 0, 16'd0, 1);
    addRow(1, 2'b11, 8'h02, 8'h03, 0, 0, 8'h05, 0, 16'd0, 1);
    addRow(1, 2'b11, 8'h04, 8'h05, 0, 0, 8'h05, 0, 16'd0, 1);
    addRow(1, 2'b11, 8'h06, 8'h07, 0, 0, 8'h05, 0, 16'd0, 0);
    addRow(1, 2'b11, 8'h08, 8'h09, 0, 0, 8'h05, 1, 16'd2, 0);
    // Release: exactly eight events, addresses 0..7.
    addRow(1, 2'b00, 8'h00, 8'h00, 1, 1, 8'h00, 1, 16'd2, 0);
    for (int k = 1; k < 8; k++) addRow(1, 2'b00, 8'h00, 8'h00, 1, 1, 8'(k), 1, 16'd2, 1);
    addRow(1, 2'b00, 8'h00, 8'h00, 1, 0, 8'h07, 1, 16'd2, 1);
    // Full queue with a pop accepts a single push without dropping.
    addRow(1, 2'b11, 8'h20, 8'h21, 0, 0, 8'h07, 1, 16'd2, 1);
    addRow(1, 2'b11, 8'h22, 8'h23, 0, 0, 8'h07, 1, 16'd2, 1);
    addRow(1, 2'b11, 8'h24, 8'h25, 0, 0, 8'h07, 1, 16'd2, 1);
    addRow(1, 2'b11, 8'h26, 8'h27, 0, 0, 8'h07, 1, 16'd2, 0);
    addRow(1, 2'b01, 8'h28, 8'h29, 1, 1, 8'h20, 1, 16'd2, 0);
    addRow(1, 2'b01, 8'h2A, 8'h2B, 1, 1, 8'h21, 1, 16'd2, 0);
    // Drain to four entries, then a one-cycle reset discards them.
    addRow(1, 2'b00, 8'h00, 8'h00, 1, 1, 8'h22, 1, 16'd2, 0);
    addRow(1, 2'b00, 8'h00, 8'h00, 1, 1, 8'h23, 1, 16'd2, 1);
    addRow(1, 2'b00, 8'h00, 8'h00, 1, 1, 8'h24, 1, 16'd2, 1);
    addRow(1, 2'b00, 8'h00, 8'h00, 1, 1, 8'h25, 1, 16'd2, 1);
    addRow(0, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 16'd0, 1);
    for (int k = 0; k < 3; k++) addRow(1, 2'b00, 8'h00, 8'h00, 1, 0, 8'h00, 0, 16'd0, 1);

    $display("[TB] table phase, %0d rows", tbl.size());
    for (int k = 0; k < tbl.size(); k++) begin
      applyStimulus(tbl[k].rst, tbl[k].valid, {tbl[k].a1, tbl[k].a0},
                    {mkdata(tbl[k].a1), mkdata(tbl[k].a0)}, tbl[k].ready, 8'h00);
      cmp($sformatf("row%0d enable", k), diff_enable, tbl[k].en);
      cmp($sformatf("row%0d address", k), diff_address, tbl[k].addr);
      cmp($sformatf("row%0d overflow", k), overflow, tbl[k].ovf);
      cmp($sformatf("row%0d drop_cnt", k), drop_cnt, tbl[k].drop);
      cmp($sformatf("row%0d wb_ready", k), wb_ready, tbl[k].rdy);
    end

    // Single writeback latency and data-half mapping.
    $display("[TB] single writeback sequence");
    applyStimulus(0, 2'b00, 16'h0, '0, 1, 8'h3C);
    applyStimulus(1, 2'b01, 16'h0005, {128'h0, 64'hA, 64'hB}, 1, 8'h3C);
    cmp("single edge0 enable", diff_enable, 1'b0);
    applyStimulus(1, 2'b00, 16'h0, '0, 1, 8'h3C);
    cmp("single enable", diff_enable, 1'b1);
    cmp("single address", diff_address, 8'h05);
    cmp("single data_0", diff_data_0, 64'hB);
    cmp("single data_1", diff_data_1, 64'hA);
    cmp("single coreid", diff_coreid, 8'h3C);
    applyStimulus(1, 2'b00, 16'h0, '0, 1, 8'h3C);
    cmp("single one-shot", diff_enable, 1'b0);

    // Randomized traffic with alternating light and heavy sink back-pressure.
    $display("[TB] random phase");
    for (int i = 0; i < 600; i++) begin
      for (int w = 0; w < 8; w++) rd[32*w +: 32] = $urandom();
      ra = 16'($urandom());
      if (((i / 40) % 2) == 0) rready = ($urandom_range(0, 9) < 8);
      else                     rready = ($urandom_range(0, 9) < 3);
      applyStimulus(($urandom_range(0, 199) != 0), 2'($urandom_range(0, 3)), ra, rd,
                    rready, 8'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
